// File: rtl/rv32_mem_pkg.sv
// Shared types and default widths for the rv32 unified-memory arbiter.
// Contents: arbiter FSM state enum, transaction owner enum, default bus widths.
package rv32_mem_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/rv32_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), i_inc (count up), i_clr (clear, wins over
// i_inc), o_cnt (current value, holds at MAX).
module rv32_sat_cnt #(
   parameter int unsigned  W   = 3,
   parameter logic [W-1:0] MAX = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/rv32_mem_arb.sv
// Shares one single-port memory between instruction fetch (IF) and load/store
// (LS). One outstanding transaction; responses are routed back to the issuer.
// LS has priority; a starvation counter forces IF through after STARVE_MAX
// consecutive LS wins over a pending fetch. An unaccepted request is locked so
// the memory-side fields stay stable until mem_gnt.
// Ports: clk/rst (sync, active-high); if_* fetch port; ls_* load/store port;
// mem_* memory port; perf_if_wait/perf_ls_wait wait-cycle counters.
// Build option: RV32_MEM_ARB_PERF_EN builds the wait counters; otherwise the
// perf outputs are tied to 0.
module rv32_mem_arb
   import rv32_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [DATA_W/8-1:0] ls_be,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [31:0]         perf_if_wait,
   output logic [31:0]         perf_ls_wait
);

   localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   arb_state_e       r_state;
   logic             r_lock_valid;
   owner_e           r_lock_owner;
   logic [CNT_W-1:0] w_starve_cnt;
   logic             w_win_valid;
   owner_e           w_win_owner;

   // Winner selection: locked owner, then starvation override, then LS priority
   always_comb begin
      w_win_valid = 1'b0;
      w_win_owner = OWN_LS;
      if (r_lock_valid) begin
         w_win_owner = r_lock_owner;
         w_win_valid = (r_lock_owner == OWN_IF) ? if_req : ls_req;
      end else if (if_req && ls_req && (w_starve_cnt == CNT_MAX)) begin
         w_win_owner = OWN_IF;
         w_win_valid = 1'b1;
      end else if (ls_req) begin
         w_win_owner = OWN_LS;
         w_win_valid = 1'b1;
      end else if (if_req) begin
         w_win_owner = OWN_IF;
         w_win_valid = 1'b1;
      end
   end

   // Memory-side mux, grants and response routing
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      if ((r_state == IDLE) && w_win_valid) begin
         mem_req = 1'b1;
         if (w_win_owner == OWN_LS) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            ls_gnt    = mem_gnt;
         end else begin
            mem_be   = '1;
            mem_addr = if_addr;
            if_gnt   = mem_gnt;
         end
      end
      if ((r_state == BUSY_IF) && mem_rvalid) begin
         if_rvalid = 1'b1;
         if_rdata  = mem_rdata;
      end
      if ((r_state == BUSY_LS) && mem_rvalid) begin
         ls_rvalid = 1'b1;
         ls_rdata  = mem_rdata;
      end
   end

   // State and lock; stray responses in IDLE fall through unused
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_lock_valid <= 1'b0;
         r_lock_owner <= OWN_IF;
      end else begin
         case (r_state)
            IDLE: begin
               if (mem_req && mem_gnt) begin
                  r_state      <= (w_win_owner == OWN_IF) ? BUSY_IF : BUSY_LS;
                  r_lock_valid <= 1'b0;
               end else if (mem_req) begin
                  r_lock_valid <= 1'b1;
                  r_lock_owner <= w_win_owner;
               end
            end
            BUSY_IF, BUSY_LS: begin
               if (mem_rvalid) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   rv32_sat_cnt #(
      .W   (CNT_W),
      .MAX (CNT_MAX)
   ) u_starve (
      .clk   (clk),
      .rst   (rst),
      .i_inc (ls_gnt && if_req),
      .i_clr (if_gnt),
      .o_cnt (w_starve_cnt)
   );

`ifdef RV32_MEM_ARB_PERF_EN
   rv32_sat_cnt #(
      .W   (32),
      .MAX (32'hFFFF_FFFF)
   ) u_perf_if (
      .clk   (clk),
      .rst   (rst),
      .i_inc (if_req && !if_gnt),
      .i_clr (1'b0),
      .o_cnt (perf_if_wait)
   );

   rv32_sat_cnt #(
      .W   (32),
      .MAX (32'hFFFF_FFFF)
   ) u_perf_ls (
      .clk   (clk),
      .rst   (rst),
      .i_inc (ls_req && !ls_gnt),
      .i_clr (1'b0),
      .o_cnt (perf_ls_wait)
   );
`else
   assign perf_if_wait = '0;
   assign perf_ls_wait = '0;
`endif

   // A locked request must stay asserted until it is accepted
   ap_lock_held: assert property (@(posedge clk) disable iff (rst)
      ((r_state == IDLE) && r_lock_valid) |-> w_win_valid);

endmodule
